// File: rtl/stream_zigzag_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_zigzag_pkg
//  Purpose  : Shared constants, zig-zag scan table, read-side state encoding
//             and the rounding quantiser used by stream_zigzag_buffer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package stream_zigzag_pkg;

  localparam int BEATS_PER_BLOCK = 16;
  localparam int COEFS_PER_BEAT  = 4;
  localparam int COEFS_PER_BLOCK = 64;

  // Stream geometry of the NASTI-stream channel carrying four coefficients.
  localparam int STREAM_DATA_W = 64;
  localparam int STREAM_DEST_W = 4;
  localparam int COEF_BITS     = 16;

  localparam logic [3:0] LAST_BEAT = 4'(BEATS_PER_BLOCK - 1);

  // Raster index (row*8+col) of each zig-zag scan position.
  localparam logic [5:0] ZIGZAG [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Divide by 2^shift rounding half away from zero; shift 0 is identity.
  // Magnitude is carried in 17 bits so that -32768 survives negation.
  function automatic logic [COEF_BITS-1:0] quantize(input logic [COEF_BITS-1:0] c,
                                                    input int unsigned shift);
    logic              neg;
    logic [COEF_BITS:0] mag;
    logic [COEF_BITS:0] rnd;
    neg = c[COEF_BITS-1];
    mag = neg ? (~{c[COEF_BITS-1], c} + 1'b1) : {1'b0, c};
    if (shift == 0) begin
      rnd = mag;
    end else begin
      rnd = (mag + ((COEF_BITS+1)'(1) << (shift - 1))) >> shift;
    end
    quantize = neg ? (COEF_BITS'(0) - rnd[COEF_BITS-1:0]) : rnd[COEF_BITS-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_zigzag_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : nasti_stream_channel
//  Purpose  : NASTI-stream channel bundle (one data channel of 64 bits).
//  Ports    : master drives t_valid/t_data/t_keep/t_strb/t_last/t_dest and
//             samples t_ready; slave is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface nasti_stream_channel
  import stream_zigzag_pkg::*;
  #(
    parameter int N_CHAN = 1,
    parameter int DATA_W = STREAM_DATA_W,
    parameter int DEST_W = STREAM_DEST_W
  );

  logic                              t_valid;
  logic                              t_ready;
  logic [N_CHAN-1:0][DATA_W-1:0]     t_data;
  logic [DATA_W/8-1:0]               t_keep;
  logic [DATA_W/8-1:0]               t_strb;
  logic                              t_last;
  logic [DEST_W-1:0]                 t_dest;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_dest,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_dest,
    output t_ready
  );

endinterface
`default_nettype wire

// File: rtl/stream_zigzag_buffer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_bank
//  Purpose  : One 8x8 coefficient block held in registers (no reset).
//  Ports    : clk              clock
//             wr_en/wr_beat    write four lanes at raster 4*wr_beat..+3
//             wr_data          the four lane values
//             zf_en/zf_from    zero every raster position >= zf_from
//             rd_addr/rd_data  four combinational read ports (raster index)
//  Revision : 1.0  initial release
// ============================================================================
module zigzag_bank
  import stream_zigzag_pkg::*;
  #(
    parameter int COEF_W = 16
  ) (
    input  wire logic                                   clk,
    input  wire logic                                   wr_en,
    input  wire logic [3:0]                             wr_beat,
    input  wire logic [COEFS_PER_BEAT-1:0][COEF_W-1:0]  wr_data,
    input  wire logic                                   zf_en,
    input  wire logic [6:0]                             zf_from,
    input  wire logic [COEFS_PER_BEAT-1:0][5:0]         rd_addr,
    output      logic [COEFS_PER_BEAT-1:0][COEF_W-1:0]  rd_data
  );

  logic [COEF_W-1:0] mem_q [COEFS_PER_BLOCK];
  logic [COEF_W-1:0] mem_d [COEFS_PER_BLOCK];

  always_comb begin
    for (int p = 0; p < COEFS_PER_BLOCK; p++) begin
      mem_d[p] = mem_q[p];
      if (zf_en && (7'(p) >= zf_from)) begin
        mem_d[p] = '0;
      end
      if (wr_en && (4'(p >> 2) == wr_beat)) begin
        mem_d[p] = wr_data[2'(p)];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Reads see this cycle's write: the read side may start draining a bank in
  // the same cycle its closing beat (or zero-fill) lands.
  always_comb begin
    for (int k = 0; k < COEFS_PER_BEAT; k++) begin
      rd_data[k] = mem_d[rd_addr[k]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_zigzag_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_zigzag_buffer
//  Purpose  : Collects 8x8 coefficient blocks (16 row-major beats of four
//             16-bit lanes) into ping-pong banks and re-emits each block in
//             JPEG zig-zag order, one beat per cycle on each side.
//  Ports    : aclk     clock
//             aresetn  synchronous active-low reset
//             in_ch    NASTI-stream slave  (row-major coefficients)
//             out_ch   NASTI-stream master (zig-zag coefficients)
//  Config   : STREAM_ZIGZAG_QUANT_EN - when defined, each output coefficient
//             is divided by 2^QUANT_SHIFT with rounding half away from zero.
//  Revision : 1.0  initial release
// ============================================================================
module stream_zigzag_buffer
  import stream_zigzag_pkg::*;
  #(
    parameter int COEF_W      = 16,
    parameter int QUANT_SHIFT = 4
  ) (
    input wire logic            aclk,
    input wire logic            aresetn,
    nasti_stream_channel.slave  in_ch,
    nasti_stream_channel.master out_ch
  );

  // ---------------------------------------------------------------- state
  rd_state_e                           state_q,     state_d;
  logic                                wr_bank_q,   wr_bank_d;
  logic [3:0]                          wr_cnt_q,    wr_cnt_d;
  logic [1:0]                          full_q,      full_d;
  logic [1:0]                          last_q,      last_d;
  logic                                rd_bank_q,   rd_bank_d;
  logic [3:0]                          rd_cnt_q,    rd_cnt_d;
  logic                                in_ready_q,  in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic [COEFS_PER_BEAT*COEF_W-1:0]    out_data_q,  out_data_d;

  // ---------------------------------------------------------------- write side
  logic                                in_acc;
  logic                                beat_ok;
  logic                                blk_last;
  logic                                blk_close;
  logic [6:0]                          zf_from;
  logic [COEFS_PER_BEAT-1:0][COEF_W-1:0] wr_lanes;

  assign in_acc    = in_ch.t_valid && in_ready_q;
  assign beat_ok   = in_acc && (in_ch.t_keep == 8'hff);
  assign blk_last  = in_acc && in_ch.t_last;
  assign blk_close = (beat_ok && (wr_cnt_q == LAST_BEAT)) || blk_last;
  // A good beat that also carries t_last is stored first; zero-fill starts after it.
  assign zf_from   = {1'b0, wr_cnt_q, 2'b00} + (beat_ok ? 7'd4 : 7'd0);

  always_comb begin
    for (int k = 0; k < COEFS_PER_BEAT; k++) begin
      wr_lanes[k] = in_ch.t_data[0][k*COEF_W +: COEF_W];
    end
  end

  // ---------------------------------------------------------------- banks
  logic [1:0]                            avail;
  logic                                  rd_load;
  logic                                  rd_src;
  logic [3:0]                            rd_beat;
  logic [COEFS_PER_BEAT-1:0][5:0]        rd_addr;
  logic [COEFS_PER_BEAT-1:0][COEF_W-1:0] bank_rd_data [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic bank_wr_en;
    logic bank_zf_en;

    assign bank_wr_en = beat_ok  && (wr_bank_q == 1'(b));
    assign bank_zf_en = blk_last && (wr_bank_q == 1'(b));
    // A bank is drainable once full, or in the very cycle its block closes.
    assign avail[b]   = full_q[b] || (blk_close && (wr_bank_q == 1'(b)));

    zigzag_bank #(
      .COEF_W (COEF_W)
    ) u_bank (
      .clk     (aclk),
      .wr_en   (bank_wr_en),
      .wr_beat (wr_cnt_q),
      .wr_data (wr_lanes),
      .zf_en   (bank_zf_en),
      .zf_from (zf_from),
      .rd_addr (rd_addr),
      .rd_data (bank_rd_data[b])
    );
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    full_d      = full_q;
    last_d      = last_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    rd_load     = 1'b0;
    rd_src      = rd_bank_q;
    rd_beat     = 4'd0;

    // Write side: fill wr_bank, close on beat 15 or t_last.
    if (blk_close) begin
      full_d[wr_bank_q] = 1'b1;
      if (blk_last) begin
        last_d[wr_bank_q] = 1'b1;
      end
      wr_bank_d = ~wr_bank_q;
      wr_cnt_d  = 4'd0;
    end else if (beat_ok) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end

    // Read side FSM.
    case (state_q)
      RD_IDLE: begin
        if (avail[rd_bank_q]) begin
          state_d     = RD_DRAIN;
          out_valid_d = 1'b1;
          rd_cnt_d    = 4'd0;
          rd_load     = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (out_valid_q && out_ch.t_ready) begin
          if (rd_cnt_q != LAST_BEAT) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            rd_beat  = rd_cnt_q + 4'd1;
            rd_load  = 1'b1;
          end else begin
            full_d[rd_bank_q] = 1'b0;
            last_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = 4'd0;
            if (avail[~rd_bank_q]) begin
              rd_load = 1'b1;
              rd_src  = ~rd_bank_q;
            end else begin
              state_d     = RD_IDLE;
              out_valid_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d     = RD_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Registered ready looks at the bank that will be written next cycle.
    in_ready_d = !full_d[wr_bank_d];
  end

  // ---------------------------------------------------------------- read datapath
  always_comb begin
    for (int k = 0; k < COEFS_PER_BEAT; k++) begin
      rd_addr[k] = ZIGZAG[{rd_beat, 2'(k)}];
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    if (rd_load) begin
      for (int k = 0; k < COEFS_PER_BEAT; k++) begin
`ifdef STREAM_ZIGZAG_QUANT_EN
        out_data_d[k*COEF_W +: COEF_W] = quantize(bank_rd_data[rd_src][k], QUANT_SHIFT);
`else
        out_data_d[k*COEF_W +: COEF_W] = bank_rd_data[rd_src][k];
`endif
      end
    end
  end

`ifndef STREAM_ZIGZAG_QUANT_EN
  logic [31:0] unused_quant_shift;
  assign unused_quant_shift = 32'(QUANT_SHIFT);
`endif

  // ---------------------------------------------------------------- registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= RD_IDLE;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= 4'd0;
      full_q      <= 2'b00;
      last_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      last_q      <= last_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign in_ch.t_ready    = in_ready_q;
  assign out_ch.t_valid   = out_valid_q;
  assign out_ch.t_data[0] = out_data_q;
  assign out_ch.t_keep    = {8{out_valid_q}};
  assign out_ch.t_strb    = {8{out_valid_q}};
  assign out_ch.t_last    = out_valid_q && last_q[rd_bank_q] && (rd_cnt_q == LAST_BEAT);
  assign out_ch.t_dest    = '0;

endmodule
`default_nettype wire

// File: tb/tb_stream_zigzag_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_stream_zigzag_buffer
//  Purpose  : Directed self-checking bench for stream_zigzag_buffer.
//  Config   : STREAM_ZIGZAG_QUANT_EN adds the rounding quantiser vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_zigzag_buffer;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  nasti_stream_channel in_if ();
  nasti_stream_channel out_if ();

  stream_zigzag_buffer #(
    .COEF_W      (16),
    .QUANT_SHIFT (4)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_ch   (in_if),
    .out_ch  (out_if)
  );

  // JPEG zig-zag scan: raster index for each scan position.
  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] blk [64];
  logic [63:0] exp_d [$];
  logic        exp_l [$];
  logic [63:0] got_d [$];
  logic        got_l [$];
  int          got_c [$];

  int          last_acc_cyc = 0;
  int          stall_cnt    = 0;
  int          hold_err     = 0;
  logic        prev_stall   = 1'b0;
  logic [63:0] prev_data    = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (out_if.t_valid && out_if.t_ready) begin
        got_d.push_back(out_if.t_data[0]);
        got_l.push_back(out_if.t_last);
        got_c.push_back(cyc);
      end
      if (in_if.t_valid && in_if.t_ready) last_acc_cyc <= cyc;
      if (in_if.t_valid && !in_if.t_ready) stall_cnt <= stall_cnt + 1;
      if (prev_stall && (!out_if.t_valid || out_if.t_data[0] != prev_data))
        hold_err <= hold_err + 1;
      prev_stall <= out_if.t_valid && !out_if.t_ready;
      prev_data  <= out_if.t_data[0];
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_coef(input logic [15:0] v);
`ifdef STREAM_ZIGZAG_QUANT_EN
    int s;
    int m;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    m = (m + 8) / 16;
    return (s < 0) ? 16'(-m) : 16'(m);
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic rdy;
    logic acc;
    acc = 1'b0;
    in_if.t_valid   = 1'b1;
    in_if.t_data[0] = d;
    in_if.t_keep    = k;
    in_if.t_strb    = k;
    in_if.t_last    = l;
    for (int i = 0; i < 400 && !acc; i++) begin
      rdy = in_if.t_ready;
      tick();
      acc = rdy;
    end
    if (!acc) check_eq("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic idle_in();
    in_if.t_valid = 1'b0;
    in_if.t_last  = 1'b0;
    in_if.t_keep  = 8'h00;
  endtask

  // Expected zig-zag stream of blk, with raster positions beyond the
  // first nbeats*4 zero-filled.
  task automatic push_exp(input int nbeats, input logic lastf);
    logic [63:0] d;
    int          p;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) begin
        p = zz[4*j+k];
        d[16*k +: 16] = exp_coef((p < 4*nbeats) ? blk[p] : 16'h0000);
      end
      exp_d.push_back(d);
      exp_l.push_back(lastf && (j == 15));
    end
  endtask

  task automatic send_block(input int nbeats, input logic lastf);
    push_exp(nbeats, lastf);
    for (int b = 0; b < nbeats; b++)
      send_beat({blk[4*b+3], blk[4*b+2], blk[4*b+1], blk[4*b]}, 8'hff,
                lastf && (b == nbeats - 1));
  endtask

  task automatic drain_check(input int n, input string tag);
    int w;
    w = 0;
    while (got_d.size() < n && w < 2000) begin
      tick();
      w++;
    end
    if (got_d.size() < n) check_eq({tag, "_count"}, 64'(got_d.size()), 64'(n));
    for (int i = 0; i < n && got_d.size() > 0 && exp_d.size() > 0; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), got_d.pop_front(), exp_d.pop_front());
      check_eq($sformatf("%s_last%0d", tag, i), 64'(got_l.pop_front()), 64'(exp_l.pop_front()));
      void'(got_c.pop_front());
    end
  endtask

  initial begin
    int acc0;
    int s0;
    int h0;
    int w;

    in_if.t_valid   = 1'b0;
    in_if.t_data[0] = '0;
    in_if.t_keep    = 8'h00;
    in_if.t_strb    = 8'h00;
    in_if.t_last    = 1'b0;
    in_if.t_dest    = '0;
    out_if.t_ready  = 1'b1;

    // ---- reset state
    tick();
    tick();
    check_eq("rst_in_ready",  64'(in_if.t_ready),  64'd0);
    check_eq("rst_out_valid", 64'(out_if.t_valid), 64'd0);
    check_eq("rst_out_keep",  64'(out_if.t_keep),  64'd0);
    check_eq("rst_out_last",  64'(out_if.t_last),  64'd0);
    aresetn = 1'b1;

    // ---- block with coef = raster index
    for (int p = 0; p < 64; p++) blk[p] = 16'(p);
    send_block(16, 1'b0);
    idle_in();
    acc0 = last_acc_cyc;
    check_eq("a_valid_latency", 64'(out_if.t_valid), 64'd1);
    check_eq("a_keep",          64'(out_if.t_keep),  64'hff);
    check_eq("a_strb",          64'(out_if.t_strb),  64'hff);
    check_eq("a_dest",          64'(out_if.t_dest),  64'd0);
    w = 0;
    while (got_d.size() < 16 && w < 200) begin tick(); w++; end
    if (got_d.size() >= 16) begin
      check_eq("a_first_cycle", 64'(got_c[0]), 64'(acc0 + 1));
`ifndef STREAM_ZIGZAG_QUANT_EN
      check_eq("a_beat0",  got_d[0],  64'h0010_0008_0001_0000);
      check_eq("a_beat1",  got_d[1],  64'h000A_0003_0002_0009);
      check_eq("a_beat15", got_d[15], 64'h003F_003E_0037_002F);
`endif
    end
    drain_check(16, "a");

    // ---- three blocks back-to-back
    s0 = stall_cnt;
    for (int p = 0; p < 64; p++) blk[p] = 16'(3*p + 100);
    send_block(16, 1'b0);
    acc0 = last_acc_cyc;
    for (int p = 0; p < 64; p++) blk[p] = 16'(1000 - 5*p);
    send_block(16, 1'b0);
    for (int p = 0; p < 64; p++) blk[p] = 16'((p * 37) ^ 16'h5a00);
    send_block(16, 1'b0);
    idle_in();
    check_eq("b_no_in_stall", 64'(stall_cnt - s0), 64'd0);
    w = 0;
    while (got_d.size() < 48 && w < 200) begin tick(); w++; end
    if (got_d.size() >= 48) begin
      check_eq("b_first_cycle",  64'(got_c[0]), 64'(acc0 + 1));
      check_eq("b_consecutive",  64'(got_c[47] - got_c[0]), 64'd47);
    end
    drain_check(48, "b");

    // ---- output stalled for 40 cycles
    h0 = hold_err;
    out_if.t_ready = 1'b0;
    fork
      begin
        for (int p = 0; p < 64; p++) blk[p] = 16'(p + 16'h0200);
        send_block(16, 1'b0);
        for (int p = 0; p < 64; p++) blk[p] = 16'(16'h8000 | p);
        send_block(16, 1'b0);
        idle_in();
        check_eq("c_in_stall", 64'(in_if.t_ready), 64'd0);
      end
      begin
        repeat (40) tick();
        out_if.t_ready = 1'b1;
      end
    join
    drain_check(32, "c");
    check_eq("c_hold_stable", 64'(hold_err - h0), 64'd0);

    // ---- early t_last on beat 5, with a dropped partial beat in between
    for (int p = 0; p < 64; p++) blk[p] = 16'h0001;
    push_exp(6, 1'b1);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b0);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b0);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b0);
    send_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'h0f, 1'b0);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b0);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b0);
    send_beat(64'h0001_0001_0001_0001, 8'hff, 1'b1);
    idle_in();
    drain_check(16, "d");

`ifdef STREAM_ZIGZAG_QUANT_EN
    // ---- rounding quantiser
    for (int p = 0; p < 64; p++) blk[p] = 16'h0000;
    blk[0]  = 16'd24;
    blk[1]  = 16'hFFE8;
    blk[8]  = 16'd7;
    blk[16] = 16'hFFF8;
    send_block(16, 1'b0);
    idle_in();
    w = 0;
    while (got_d.size() < 1 && w < 200) begin tick(); w++; end
    if (got_d.size() >= 1) check_eq("q_beat0", got_d[0], 64'hFFFF_0000_FFFE_0002);
    drain_check(16, "q");
`endif

    // ---- reset in the middle of draining
    for (int p = 0; p < 64; p++) blk[p] = 16'(p + 16'h0700);
    send_block(16, 1'b0);
    idle_in();
    w = 0;
    while (got_d.size() < 7 && w < 200) begin tick(); w++; end
    check_eq("e_reached_beat7", 64'(got_d.size() >= 7), 64'd1);
    aresetn = 1'b0;
    tick();
    check_eq("e_rst_valid", 64'(out_if.t_valid), 64'd0);
    check_eq("e_rst_ready", 64'(in_if.t_ready),  64'd0);
    aresetn = 1'b1;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    exp_d.delete();
    exp_l.delete();
    for (int p = 0; p < 64; p++) blk[p] = 16'(16'h4000 + 2*p);
    send_block(16, 1'b0);
    idle_in();
    drain_check(16, "e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
